// File: rtl/tmu_texel_fetch_filter.sv
`default_nettype none
// ============================================================================
// Module      : tmu_texel_fetch_filter
// Description : Multi-beat texel-quad fetch over 1/2/4 memory read ports,
//               followed by a per-channel bilinear (or nearest) filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tmu_texel_fetch_filter #(
    parameter int PIXEL_WIDTH     = 32,
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH      = 17,
    parameter int NUM_READ_PORTS  = 4,
    parameter int MEM_LATENCY     = 1,
    parameter int SUB_COORD_WIDTH = 8,
    parameter int USER_WIDTH      = 32
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [4*ADDR_WIDTH-1:0]               s_texelAddr,
    input  logic [SUB_COORD_WIDTH-1:0]            s_subCoordS,
    input  logic [SUB_COORD_WIDTH-1:0]            s_subCoordT,
    input  logic                                  s_filterEnable,
    input  logic [USER_WIDTH-1:0]                 s_user,
    output logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  mem_addr,
    output logic [NUM_READ_PORTS-1:0]             mem_rden,
    input  logic [NUM_READ_PORTS*PIXEL_WIDTH-1:0] mem_rdata,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [PIXEL_WIDTH-1:0]                m_texel,
    output logic [USER_WIDTH-1:0]                 m_user
);

    localparam int CHANNELS       = PIXEL_WIDTH / SUB_PIXEL_WIDTH;
    localparam int BEATS_BILINEAR = (NUM_READ_PORTS > 0) ? 4 / NUM_READ_PORTS : 1;
    localparam int IW             = SUB_PIXEL_WIDTH + SUB_COORD_WIDTH + 1;

    if (!(NUM_READ_PORTS == 1 || NUM_READ_PORTS == 2 || NUM_READ_PORTS == 4)) begin : g_bad_read_ports
        $error("NUM_READ_PORTS must be 1, 2 or 4");
    end
    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("MEM_LATENCY must be at least 1");
    end
    if (PIXEL_WIDTH % SUB_PIXEL_WIDTH != 0) begin : g_bad_pixel_width
        $error("PIXEL_WIDTH must be a multiple of SUB_PIXEL_WIDTH");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FILTER = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0]        addr_q [4];
    logic [PIXEL_WIDTH-1:0]       quad   [4];
    logic [SUB_COORD_WIDTH-1:0]   coord_s, coord_t;
    logic                         filter_en;
    logic [USER_WIDTH-1:0]        user_q;
    logic [1:0]                   beat;
    logic [1:0]                   last_beat;
    logic [MEM_LATENCY-1:0]       pipe_vld;
    logic [MEM_LATENCY-1:0][1:0]  pipe_beat;
    logic                         capture;
    logic [1:0]                   cap_beat;
    logic [PIXEL_WIDTH-1:0]       filtered;

    // Quad slot fetched by port p during beat b.
    function automatic logic [1:0] slot_of(input logic [1:0] b, input int p);
        return 2'(int'(b) * NUM_READ_PORTS + p);
    endfunction

    function automatic logic [SUB_PIXEL_WIDTH-1:0] lerp(
        input logic [SUB_PIXEL_WIDTH-1:0] a,
        input logic [SUB_PIXEL_WIDTH-1:0] b,
        input logic [SUB_COORD_WIDTH-1:0] f
    );
        logic [IW-1:0] full;
        logic [IW-1:0] sum;
        full = IW'(1) << SUB_COORD_WIDTH;
        sum  = IW'(a) * (full - IW'(f)) + IW'(b) * IW'(f);
        return sum[SUB_COORD_WIDTH +: SUB_PIXEL_WIDTH];
    endfunction

    assign last_beat = filter_en ? 2'(BEATS_BILINEAR - 1) : 2'd0;
    assign capture   = pipe_vld[MEM_LATENCY-1];
    assign cap_beat  = pipe_beat[MEM_LATENCY-1];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = (state == ST_IDLE) && !areset;
        m_valid    = (state == ST_OUT);
        mem_rden   = '0;
        mem_addr   = '0;
        case (state)
            ST_IDLE:   if (s_valid) next_state = ST_ISSUE;
            ST_ISSUE: begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    if (filter_en || p == 0) begin
                        mem_rden[p]                       = 1'b1;
                        mem_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[slot_of(beat, p)];
                    end
                end
                if (beat == last_beat) next_state = ST_WAIT;
            end
            ST_WAIT:   if (capture && cap_beat == last_beat) next_state = ST_FILTER;
            ST_FILTER: next_state = ST_OUT;
            ST_OUT:    if (m_ready) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        filtered = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            filtered[c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH] = lerp(
                lerp(quad[0][c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH],
                     quad[1][c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH], coord_s),
                lerp(quad[2][c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH],
                     quad[3][c*SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH], coord_s),
                coord_t);
        end
    end

    // The issue tracker tags each beat so returning data lands in its own slot;
    // clearing it on reset drops any reads still in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
                quad[i]   <= '0;
            end
            coord_s   <= '0;
            coord_t   <= '0;
            filter_en <= 1'b0;
            user_q    <= '0;
            beat      <= 2'd0;
            pipe_vld  <= '0;
            pipe_beat <= '0;
            m_texel   <= '0;
            m_user    <= '0;
        end else begin
            if (state == ST_IDLE && s_valid) begin
                for (int i = 0; i < 4; i++) begin
                    addr_q[i] <= s_texelAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
                coord_s   <= s_subCoordS;
                coord_t   <= s_subCoordT;
                filter_en <= s_filterEnable;
                user_q    <= s_user;
            end
            beat         <= (state == ST_ISSUE) ? beat + 2'd1 : 2'd0;
            pipe_vld[0]  <= (state == ST_ISSUE);
            pipe_beat[0] <= beat;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_beat[i] <= pipe_beat[i-1];
            end
            if (capture) begin
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    if (filter_en || p == 0) begin
                        quad[slot_of(cap_beat, p)] <= mem_rdata[p*PIXEL_WIDTH +: PIXEL_WIDTH];
                    end
                end
            end
            if (state == ST_FILTER) begin
                m_texel <= filter_en ? filtered : quad[0];
                m_user  <= user_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmu_texel_fetch_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmu_texel_fetch_filter
// Description : Three DUT configurations (4/1, 1/2, 2/3 ports/latency) against
//               a latency-modelled texture memory and an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmu_texel_fetch_filter;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic [2:0]  s_valid, s_ready, m_ready, m_valid;
    logic [67:0] s_addr;
    logic [7:0]  s_s, s_t;
    logic        s_filt;
    logic [31:0] s_user;
    logic [31:0] m_texel_v [3];
    logic [31:0] m_user_v  [3];
    logic [67:0] maddr [3];
    logic [3:0]  mren  [3];

    logic [67:0]  addr0;
    logic [16:0]  addr1;
    logic [33:0]  addr2;
    logic [3:0]   rden0;
    logic [0:0]   rden1;
    logic [1:0]   rden2;
    logic [127:0] rd0_q;
    logic [31:0]  rd1_q [2];
    logic [63:0]  rd2_q [3];
    logic [31:0]  rdata1;
    logic [63:0]  rdata2;

    logic [31:0] tex [0:131071];

    int ncmp  = 0;
    int nfail = 0;

    assign maddr[0] = addr0;
    assign maddr[1] = {51'b0, addr1};
    assign maddr[2] = {34'b0, addr2};
    assign mren[0]  = rden0;
    assign mren[1]  = {3'b0, rden1};
    assign mren[2]  = {2'b0, rden2};
    assign rdata1   = rd1_q[1];
    assign rdata2   = rd2_q[2];

    tmu_texel_fetch_filter #(.NUM_READ_PORTS(4), .MEM_LATENCY(1)) u_dut0 (
        .aclk(clk), .areset(areset), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_texelAddr(s_addr), .s_subCoordS(s_s), .s_subCoordT(s_t),
        .s_filterEnable(s_filt), .s_user(s_user),
        .mem_addr(addr0), .mem_rden(rden0), .mem_rdata(rd0_q),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_texel(m_texel_v[0]), .m_user(m_user_v[0]));

    tmu_texel_fetch_filter #(.NUM_READ_PORTS(1), .MEM_LATENCY(2)) u_dut1 (
        .aclk(clk), .areset(areset), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_texelAddr(s_addr), .s_subCoordS(s_s), .s_subCoordT(s_t),
        .s_filterEnable(s_filt), .s_user(s_user),
        .mem_addr(addr1), .mem_rden(rden1), .mem_rdata(rdata1),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_texel(m_texel_v[1]), .m_user(m_user_v[1]));

    tmu_texel_fetch_filter #(.NUM_READ_PORTS(2), .MEM_LATENCY(3)) u_dut2 (
        .aclk(clk), .areset(areset), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_texelAddr(s_addr), .s_subCoordS(s_s), .s_subCoordT(s_t),
        .s_filterEnable(s_filt), .s_user(s_user),
        .mem_addr(addr2), .mem_rden(rden2), .mem_rdata(rdata2),
        .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_texel(m_texel_v[2]), .m_user(m_user_v[2]));

    // Disabled ports return junk so data from a non-enabled port is noticed.
    function automatic logic [127:0] rdfn(input logic [67:0] a, input logic [3:0] en);
        logic [127:0] r;
        for (int p = 0; p < 4; p++)
            r[p*32 +: 32] = en[p] ? tex[a[p*17 +: 17]] : (32'hBAD0_0000 | p);
        return r;
    endfunction

    always @(posedge clk) begin
        rd0_q    <= rdfn(maddr[0], mren[0]);
        rd1_q[0] <= rdfn(maddr[1], mren[1]) >> 0;
        rd1_q[1] <= rd1_q[0];
        rd2_q[0] <= 64'(rdfn(maddr[2], mren[2]));
        rd2_q[1] <= rd2_q[0];
        rd2_q[2] <= rd2_q[1];
    end

    function automatic int np_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 2);
    endfunction
    function automatic int lat_of(input int d);
        return d + 1;
    endfunction

    function automatic logic [31:0] model(input logic [3:0][31:0] tx, input logic [7:0] S,
                                          input logic [7:0] T, input logic filt);
        logic [31:0] r;
        int a, b, c, e, r0, r1;
        if (!filt) return tx[0];
        for (int ch = 0; ch < 4; ch++) begin
            a  = int'(tx[0][ch*8 +: 8]);
            b  = int'(tx[1][ch*8 +: 8]);
            c  = int'(tx[2][ch*8 +: 8]);
            e  = int'(tx[3][ch*8 +: 8]);
            r0 = (a * (256 - int'(S)) + b * int'(S)) / 256;
            r1 = (c * (256 - int'(S)) + e * int'(S)) / 256;
            r[ch*8 +: 8] = 8'((r0 * (256 - int'(T)) + r1 * int'(T)) / 256);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0][31:0] tx, input logic [7:0] S, input logic [7:0] T,
                         input logic filt, input logic [31:0] user, output logic [16:0] a [4]);
        int base;
        base = $urandom_range(0, 100000);
        a[0] = 17'(base);
        a[1] = 17'(base + 1);
        a[2] = 17'(base + 64);
        a[3] = 17'(base + 65);
        for (int i = 0; i < 4; i++) tex[a[i]] = tx[i];
        s_addr = {a[3], a[2], a[1], a[0]};
        s_s    = S;
        s_t    = T;
        s_filt = filt;
        s_user = user;
    endtask

    task automatic run(input int d, input logic [3:0][31:0] tx, input logic [7:0] S, input logic [7:0] T,
                       input logic filt, input logic [31:0] user, input int bp, output logic [31:0] got);
        logic [16:0] a [4];
        logic [31:0] exp_t;
        int np, nb, cyc, beats;
        np    = np_of(d);
        nb    = filt ? 4 / np : 1;
        exp_t = model(tx, S, T, filt);
        @(negedge clk);
        drive(tx, S, T, filt, user, a);
        s_valid[d] = 1'b1;
        m_ready[d] = (bp == 0);
        cyc = 0;
        while (!s_ready[d] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("accept", s_ready[d], 1);
        @(negedge clk);
        s_valid[d] = 1'b0;
        cyc   = 1;
        beats = 0;
        while (!m_valid[d] && cyc < 40) begin
            if (mren[d] != 0) begin
                check("beat_cycle", cyc, beats + 1);
                check("rden", mren[d], filt ? ((1 << np) - 1) : 1);
                for (int p = 0; p < np; p++)
                    if (mren[d][p] && beats * np + p < 4)
                        check("mem_addr", maddr[d][p*17 +: 17], a[beats*np + p]);
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, nb + lat_of(d) + 2);
        check("beats", beats, nb);
        check("m_valid", m_valid[d], 1);
        check("m_texel", m_texel_v[d], exp_t);
        check("m_user", m_user_v[d], user);
        got = m_texel_v[d];
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            s_valid[d] = 1'b1;
            s_user     = $urandom;
            check("bp_valid", m_valid[d], 1);
            check("bp_texel", m_texel_v[d], exp_t);
            check("bp_user", m_user_v[d], user);
            check("bp_sready", s_ready[d], 0);
        end
        if (bp > 0) begin
            @(negedge clk);
            check("bp_busy_sready", s_ready[d], 0);
            s_valid[d] = 1'b0;
            m_ready[d] = 1'b1;
        end
        @(negedge clk);
        check("drop_valid", m_valid[d], 0);
        check("idle_sready", s_ready[d], 1);
        m_ready[d] = 1'b1;
    endtask

    initial begin
        logic [31:0] got;
        logic [16:0] a [4];
        logic [3:0][31:0] tx;
        int cyc;

        areset  = 1'b1;
        s_valid = '0;
        m_ready = '1;
        s_addr  = '0;
        s_s     = '0;
        s_t     = '0;
        s_filt  = 1'b0;
        s_user  = '0;
        repeat (3) @(negedge clk);
        check("rst_sready", s_ready, 3'b000);
        check("rst_mvalid", m_valid, 3'b000);
        check("rst_rden", {mren[0], mren[1], mren[2]}, 12'h0);
        check("rst_addr", maddr[0], 68'h0);
        areset = 1'b0;
        @(negedge clk);
        check("post_rst_sready", s_ready, 3'b111);
        check("post_rst_texel", m_texel_v[0], 32'h0);
        check("post_rst_user", m_user_v[0], 32'h0);

        // 4 ports, latency 1: half-way between black and white rows
        tx = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        run(0, tx, 8'h80, 8'h80, 1'b1, 32'h1111_2222, 0, got);
        check("tp_quad4", got, 32'h7F7F_7F7F);

        // single port, latency 2
        tx = {$urandom, $urandom, 32'hFFFF_FFFF, 32'h0};
        run(1, tx, 8'h80, 8'h00, 1'b1, 32'h3333_4444, 0, got);
        check("tp_port1", got, 32'h7F7F_7F7F);

        // nearest, 2 ports
        tx = {$urandom, $urandom, $urandom, 32'h1234_5678};
        run(2, tx, 8'hFF, 8'hFF, 1'b0, 32'hCAFE_F00D, 0, got);
        check("tp_nearest", got, 32'h1234_5678);

        // backpressure
        tx = {$urandom, $urandom, $urandom, $urandom};
        run(0, tx, 8'h37, 8'hC1, 1'b1, 32'h5555_6666, 5, got);

        // maximum weight truncates rather than rounds
        tx = {$urandom, $urandom, 32'hFFFF_FFFF, 32'h0};
        run(0, tx, 8'hFF, 8'h00, 1'b1, 32'h7777_8888, 0, got);
        check("tp_edge_ff", got, 32'hFEFE_FEFE);

        // zero weights return texel00 exactly
        tx = {$urandom, $urandom, $urandom, 32'hA5C3_1E77};
        run(2, tx, 8'h00, 8'h00, 1'b1, 32'h9999_AAAA, 0, got);
        check("tp_zero_w", got, 32'hA5C3_1E77);

        // reset while waiting for read data
        tx = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        drive(tx, 8'h40, 8'h40, 1'b1, 32'hDEAD_0001, a);
        s_valid[1] = 1'b1;
        cyc = 0;
        while (!s_ready[1] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_test_accept", s_ready[1], 1);
        repeat (5) @(negedge clk);
        s_valid[1] = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        check("midrst_sready", s_ready[1], 0);
        check("midrst_mvalid", m_valid[1], 0);
        areset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("after_rst_mvalid", m_valid[1], 0);
            check("after_rst_rden", mren[1], 0);
            check("after_rst_sready", s_ready[1], 1);
        end
        tx = {$urandom, $urandom, $urandom, $urandom};
        run(1, tx, 8'h9A, 8'h21, 1'b1, 32'hBEEF_0002, 0, got);

        // randomized traffic over all three configurations
        for (int it = 0; it < 12; it++) begin
            tx = {$urandom, $urandom, $urandom, $urandom};
            run(it % 3, tx, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                $urandom, $urandom_range(0, 3), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
